// File: rtl/fifo_sync_param_pkg.sv
// Shared types and sizing helpers for the parametrised synchronous FIFO.
// Imported by the interface, the storage array and the FIFO top.
package fifo_pkg;

  typedef enum logic {
    MODE_STD  = 1'b0,
    MODE_FWFT = 1'b1
  } read_mode_e;

  // Occupancy must be able to hold the value FIFO_DEPTH itself, not just DEPTH-1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int addr_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_sync_param_if.sv
// Stream-side handshake, data and status bundle of fifo_sync_param.
// master = producer/consumer side, slave = the FIFO.
interface fifo_sync_param_if #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
);
  import fifo_pkg::*;

  localparam int CNT_W = cnt_width(FIFO_DEPTH);

  logic                  flush;
  logic                  wr_en;
  logic                  rd_en;
  logic [FIFO_WIDTH-1:0] data_in;
  logic [FIFO_WIDTH-1:0] data_out;
  logic                  wr_ack;
  logic                  overflow;
  logic                  underflow;
  logic                  full;
  logic                  empty;
  logic                  almostfull;
  logic                  almostempty;
  logic [CNT_W-1:0]      count;

  modport master (
    output flush, wr_en, rd_en, data_in,
    input  data_out, wr_ack, overflow, underflow,
    input  full, empty, almostfull, almostempty, count
  );

  modport slave (
    input  flush, wr_en, rd_en, data_in,
    output data_out, wr_ack, overflow, underflow,
    output full, empty, almostfull, almostempty, count
  );

endinterface

// File: rtl/fifo_sync_param_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  localparam int ADDR_W    = addr_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [FIFO_WIDTH-1:0] wr_data,
  input  logic [ADDR_W-1:0]     rd_addr,
  output logic [FIFO_WIDTH-1:0] rd_data
);

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_sync_param.sv
// Synchronous FIFO with arbitrary depth, programmable almost flags, flush
// and selectable standard / first-word-fall-through read mode.
module fifo_sync_param
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1,
  parameter int FWFT       = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_sync_param_if.slave   bus
);

  localparam int CNT_W  = cnt_width(FIFO_DEPTH);
  localparam int ADDR_W = addr_width(FIFO_DEPTH);
  localparam read_mode_e READ_MODE = (FWFT != 0) ? MODE_FWFT : MODE_STD;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  AF_CNT    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  AE_CNT    = CNT_W'(AE_LEVEL);

  if (FIFO_DEPTH < 2) begin : g_bad_depth
    $error("fifo_sync_param: FIFO_DEPTH must be >= 2");
  end
  if (AF_LEVEL < 1 || AF_LEVEL > FIFO_DEPTH) begin : g_bad_af
    $error("fifo_sync_param: AF_LEVEL must be in 1..FIFO_DEPTH");
  end
  if (AE_LEVEL < 0 || AE_LEVEL > FIFO_DEPTH - 1) begin : g_bad_ae
    $error("fifo_sync_param: AE_LEVEL must be in 0..FIFO_DEPTH-1");
  end

  logic [ADDR_W-1:0]     wr_ptr;
  logic [ADDR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  wr_acc;
  logic                  rd_acc;
  logic [FIFO_WIDTH-1:0] mem_rdata;

  // Depth need not be a power of two, so wrap is an explicit compare.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] ptr);
    return (ptr == LAST_ADDR) ? '0 : ptr + ADDR_W'(1);
  endfunction

  assign full_w  = (count_q == DEPTH_CNT);
  assign empty_w = (count_q == '0);

  assign wr_acc = bus.wr_en && !full_w  && !bus.flush;
  assign rd_acc = bus.rd_en && !empty_w && !bus.flush;

  assign bus.full        = full_w;
  assign bus.empty       = empty_w;
  assign bus.almostfull  = (count_q >= AF_CNT);
  assign bus.almostempty = (count_q <= AE_CNT);
  assign bus.count       = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (rd_acc) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Pulses describe the previous cycle's request; a flush cycle reports nothing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.wr_ack    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      bus.wr_ack    <= wr_acc;
      bus.overflow  <= bus.wr_en && full_w  && !bus.flush;
      bus.underflow <= bus.rd_en && empty_w && !bus.flush;
    end
  end

  fifo_mem #(
    .FIFO_WIDTH (FIFO_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (mem_rdata)
  );

  if (READ_MODE == MODE_FWFT) begin : g_fwft
    assign bus.data_out = empty_w ? '0 : mem_rdata;
  end else begin : g_std
    logic [FIFO_WIDTH-1:0] dout_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (rd_acc) begin
        dout_q <= mem_rdata;
      end
    end

    assign bus.data_out = dout_q;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// Drives a standard-mode (depth 6) and an FWFT-mode (depth 5) FIFO with the
// same stimulus and compares both against list-based reference models.
module tb_fifo_sync_param;

  localparam int W       = 16;
  localparam int A_DEPTH = 6;
  localparam int A_AF    = 5;
  localparam int A_AE    = 2;
  localparam int B_DEPTH = 5;
  localparam int B_AF    = 3;
  localparam int B_AE    = 1;

  logic clk;
  logic rst_n;

  int checks   = 0;
  int failures = 0;

  fifo_sync_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(A_DEPTH)) a_if ();
  fifo_sync_param_if #(.FIFO_WIDTH(W), .FIFO_DEPTH(B_DEPTH)) b_if ();

  fifo_sync_param #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (A_DEPTH),
    .AF_LEVEL   (A_AF),
    .AE_LEVEL   (A_AE),
    .FWFT       (0)
  ) dut_std (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a_if.slave)
  );

  fifo_sync_param #(
    .FIFO_WIDTH (W),
    .FIFO_DEPTH (B_DEPTH),
    .AF_LEVEL   (B_AF),
    .AE_LEVEL   (B_AE),
    .FWFT       (1)
  ) dut_fwft (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: index 0 = standard FIFO, index 1 = FWFT FIFO; list[0] is the head.
  logic [W-1:0] mlist [2][8];
  int           mlen  [2];
  logic [W-1:0] mdout [2];
  bit           mack  [2];
  bit           movf  [2];
  bit           mudf  [2];

  function automatic int depthOf(input int i);
    return (i == 0) ? A_DEPTH : B_DEPTH;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mlen[i]  = 0;
      mdout[i] = '0;
      mack[i]  = 1'b0;
      movf[i]  = 1'b0;
      mudf[i]  = 1'b0;
    end
  endtask

  task automatic modelStep(input int i, input bit f, input bit w, input bit r, input logic [W-1:0] d);
    bit is_full;
    bit is_empty;
    if (f) begin
      mlen[i] = 0;
      mack[i] = 1'b0;
      movf[i] = 1'b0;
      mudf[i] = 1'b0;
    end else begin
      is_full  = (mlen[i] == depthOf(i));
      is_empty = (mlen[i] == 0);
      mack[i]  = w && !is_full;
      movf[i]  = w && is_full;
      mudf[i]  = r && is_empty;
      if (r && !is_empty) begin
        if (i == 0) mdout[i] = mlist[i][0];
        for (int k = 0; k < 7; k++) mlist[i][k] = mlist[i][k+1];
        mlen[i]--;
      end
      if (w && !is_full) begin
        mlist[i][mlen[i]] = d;
        mlen[i]++;
      end
    end
  endtask

  task automatic checkDut(input string name, input int i,
                          input logic [31:0] cnt, input logic fl, input logic em,
                          input logic af, input logic ae, input logic ack,
                          input logic ovf, input logic udf, input logic [W-1:0] dout);
    int af_lvl;
    int ae_lvl;
    logic [W-1:0] exp_dout;
    af_lvl   = (i == 0) ? A_AF : B_AF;
    ae_lvl   = (i == 0) ? A_AE : B_AE;
    exp_dout = (i == 0) ? mdout[i] : ((mlen[i] > 0) ? mlist[i][0] : '0);
    checkOutput({name, ".count"},     cnt, 32'(mlen[i]));
    checkOutput({name, ".full"},      32'(fl),  32'(mlen[i] == depthOf(i)));
    checkOutput({name, ".empty"},     32'(em),  32'(mlen[i] == 0));
    checkOutput({name, ".almostfull"},  32'(af), 32'(mlen[i] >= af_lvl));
    checkOutput({name, ".almostempty"}, 32'(ae), 32'(mlen[i] <= ae_lvl));
    checkOutput({name, ".wr_ack"},    32'(ack), 32'(mack[i]));
    checkOutput({name, ".overflow"},  32'(ovf), 32'(movf[i]));
    checkOutput({name, ".underflow"}, 32'(udf), 32'(mudf[i]));
    checkOutput({name, ".data_out"},  32'(dout), 32'(exp_dout));
  endtask

  task automatic checkAll();
    checkDut("std", 0, 32'(a_if.count), a_if.full, a_if.empty, a_if.almostfull,
             a_if.almostempty, a_if.wr_ack, a_if.overflow, a_if.underflow, a_if.data_out);
    checkDut("fwft", 1, 32'(b_if.count), b_if.full, b_if.empty, b_if.almostfull,
             b_if.almostempty, b_if.wr_ack, b_if.overflow, b_if.underflow, b_if.data_out);
  endtask

  // One clock cycle: drive both FIFOs, advance the models at the edge, check #1 later.
  task automatic applyStimulus(input bit f, input bit w, input bit r, input logic [W-1:0] d);
    a_if.flush = f;  a_if.wr_en = w;  a_if.rd_en = r;  a_if.data_in = d;
    b_if.flush = f;  b_if.wr_en = w;  b_if.rd_en = r;  b_if.data_in = d;
    @(posedge clk);
    modelStep(0, f, w, r, d);
    modelStep(1, f, w, r, d);
    #1;
    checkAll();
  endtask

  task automatic randomSteps(input int n);
    bit f, w, r;
    int wp;
    for (int s = 0; s < n; s++) begin
      wp = ((s / 40) % 2 == 0) ? 75 : 30;
      w  = ($urandom_range(99) < wp);
      r  = ($urandom_range(99) < (100 - wp));
      f  = ($urandom_range(99) < 3);
      applyStimulus(f, w, r, W'($urandom));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    a_if.flush = 1'b0; a_if.wr_en = 1'b0; a_if.rd_en = 1'b0; a_if.data_in = '0;
    b_if.flush = 1'b0; b_if.wr_en = 1'b0; b_if.rd_en = 1'b0; b_if.data_in = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkAll();
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(0, 0, 0, '0);

    for (int k = 0; k < 6; k++) applyStimulus(0, 1, 0, W'(16'h00A0 + k));
    checkOutput("std.full_at_6", 32'(a_if.full), 32'd1);
    applyStimulus(0, 1, 0, 16'h00A6);
    checkOutput("std.ovf_7th",   32'(a_if.overflow), 32'd1);
    checkOutput("std.ack_7th",   32'(a_if.wr_ack), 32'd0);
    checkOutput("std.count_7th", 32'(a_if.count), 32'd6);

    applyStimulus(0, 1, 1, 16'h00B0);
    checkOutput("std.rw_full_dout",  32'(a_if.data_out), 32'h00A0);
    checkOutput("std.rw_full_ovf",   32'(a_if.overflow), 32'd1);
    checkOutput("std.rw_full_count", 32'(a_if.count), 32'd5);

    applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 0, 1, '0);
    for (int k = 0; k < 8; k++) applyStimulus(0, 1, 1, W'(16'h00C0 + k));
    checkOutput("std.rw_mid_count", 32'(a_if.count), 32'd3);

    while (mlen[0] > 0 || mlen[1] > 0) applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 0, 1, '0);
    checkOutput("std.udf_empty", 32'(a_if.underflow), 32'd1);
    applyStimulus(0, 1, 1, 16'h00D1);
    checkOutput("std.rw_empty_udf",   32'(a_if.underflow), 32'd1);
    checkOutput("std.rw_empty_count", 32'(a_if.count), 32'd1);

    applyStimulus(0, 0, 1, '0);
    applyStimulus(0, 1, 0, 16'h1234);
    checkOutput("fwft.head",  32'(b_if.data_out), 32'h1234);
    checkOutput("fwft.empty", 32'(b_if.empty), 32'd0);
    applyStimulus(0, 0, 1, '0);
    checkOutput("fwft.pop_empty", 32'(b_if.empty), 32'd1);
    checkOutput("fwft.pop_dout",  32'(b_if.data_out), 32'd0);

    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 0, W'(16'h00E0 + k));
    checkOutput("std.ae_off_at_4", 32'(a_if.almostempty), 32'd0);
    applyStimulus(1, 1, 0, 16'h00EF);
    checkOutput("std.flush_count", 32'(a_if.count), 32'd0);
    checkOutput("std.flush_ack",   32'(a_if.wr_ack), 32'd0);
    checkOutput("std.flush_empty", 32'(a_if.empty), 32'd1);

    randomSteps(400);

    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 0, W'($urandom));
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkAll();
    checkOutput("std.midrst_count", 32'(a_if.count), 32'd0);
    a_if.wr_en = 1'b0; b_if.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, '0);

    randomSteps(100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Parametrised synchronous FIFO; next generation of the team's single-clock FIFO.
- Adds:
  - arbitrary (non-power-of-2) depth
  - programmable almost-full/almost-empty thresholds
  - occupancy count output
  - synchronous flush
  - selectable standard or first-word-fall-through (FWFT) read mode
- Sits between stream producers and consumers in the datapath.
- Keeps the existing FIFO status/handshake signal set, so existing benches and monitors extend to it.

Parameters:
- FIFO_WIDTH, 16: data word width, >=1.
- FIFO_DEPTH, 8: number of entries, >=2, any integer.
- AF_LEVEL, FIFO_DEPTH-1: almostfull asserted when count >= AF_LEVEL; legal range 1..FIFO_DEPTH.
- AE_LEVEL, 1: almostempty asserted when count <= AE_LEVEL; legal range 0..FIFO_DEPTH-1.
- FWFT, 0: 0 = standard registered read; 1 = first-word-fall-through.
- Derived localparam CNT_W = $clog2(FIFO_DEPTH+1). Derived localparam ADDR_W = max(1,$clog2(FIFO_DEPTH)).

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous clear of contents
- data_in  input  FIFO_WIDTH  write data
- wr_en  input  1  write request
- rd_en  input  1  read request (pop)
- data_out  output  FIFO_WIDTH  read data
- wr_ack  output  1  previous-cycle write accepted
- overflow  output  1  previous-cycle write rejected (full)
- underflow  output  1  previous-cycle read rejected (empty)
- full  output  1  count == FIFO_DEPTH
- empty  output  1  count == 0
- almostfull  output  1  count >= AF_LEVEL
- almostempty  output  1  count <= AE_LEVEL
- count  output  CNT_W  current occupancy

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - wr_ptr = rd_ptr = count = 0
  - data_out = 0
  - wr_ack = overflow = underflow = 0
  - empty = 1, almostempty = 1, full = 0, almostfull = 0
  - Memory contents are not reset.
- Status flags:
  - full, empty, almostfull, almostempty and count are combinational from registered count.
  - They reflect state after the last edge.
- Accept rules, evaluated on pre-edge state:
  - write accepted iff wr_en && !full
  - read accepted iff rd_en && !empty
- Simultaneous wr_en && rd_en:
  - full: read accepted, write rejected (overflow=1).
  - empty: write accepted, read rejected (underflow=1).
  - Otherwise: both accepted, count unchanged.
- Count update: count += wr_acc - rd_acc. It never exceeds FIFO_DEPTH and never wraps below 0.
- Pointer wrap: pointers wrap from FIFO_DEPTH-1 to 0 via explicit compare, not a power-of-2 rollover.
- Handshake outputs:
  - wr_ack, overflow and underflow are registered, one-cycle pulses, asserted the cycle after the request.
  - They are 0 when no request occurred.
- Standard mode (FWFT=0):
  - Accepted read loads data_out <= mem[rd_ptr] at the edge; latency 1.
  - data_out holds its value otherwise, including on a rejected read.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously; the head word is valid whenever !empty.
  - rd_en pops the word.
  - A word written into an empty FIFO is visible on data_out the cycle after the write edge.
  - When empty, data_out = 0.
- Flush:
  - flush=1 at an edge zeroes pointers and count.
  - Flush overrides wr_en and rd_en in the same cycle.
  - wr_ack = overflow = underflow = 0 the following cycle.
  - In standard mode, data_out is unchanged.
- Reset mid-operation: asynchronously forces reset values immediately; resumes on the first edge after rst_n release.
- Elaboration checks: illegal parameters (FIFO_DEPTH<2, AF_LEVEL or AE_LEVEL outside their ranges) raise $error.

Decomposition:
- Package fifo_pkg holds:
  - a function computing CNT_W/ADDR_W
  - an enum for read mode: MODE_STD, MODE_FWFT
- Sub-module fifo_mem: simple dual-port storage (1 write port, 1 async read port), parametrised by FIFO_WIDTH and FIFO_DEPTH.
- Top fifo_sync_param holds pointers, count, flags and the handshake registers.

Test Plan:
- Reset then idle -> empty=1, almostempty=1, full=0, count=0, data_out=0; all pulses 0.
- DEPTH=6, write 6 words 0xA0..0xA5, then a 7th -> wr_ack=1 for 6 cycles; full=1 at count=6; 7th gives overflow=1, wr_ack=0, count stays 6; almostfull=1 from count=5.
- Full FIFO, wr_en=rd_en=1 -> read returns 0xA0, write rejected with overflow=1, count=5. Then both asserted at count=3 -> count stays 3; pointers wrap past index 5 correctly.
- Empty FIFO, rd_en=1 -> underflow=1 the next cycle, data_out unchanged. Then wr_en=rd_en=1 on empty -> write accepted, underflow=1, count=1.
- FWFT=1, write 0x1234 into empty -> data_out=0x1234 the cycle after the write edge, empty=0. rd_en pop -> empty=1, data_out=0.
- Count=4 with AE_LEVEL=2, assert flush together with wr_en -> count=0, empty=1, wr_ack=0. rst_n dropped mid-burst -> outputs go to reset values without waiting for a clock edge.
